// File: rtl/k6502_seq_pkg.sv
// Shared k6502 sequencer definitions: cycle encodings, interrupt-flag ordering
// and the opcode forced into the instruction register for interrupt sequences.
package k6502_defs;

  localparam int unsigned CYC_W = 6;

  typedef enum logic [CYC_W-1:0] {
    C_N = 6'h00,
    C_0 = 6'h01,
    C_1 = 6'h02,
    C_2 = 6'h04,
    C_3 = 6'h08,
    C_4 = 6'h10,
    C_5 = 6'h20
  } cyc_e;

  // Bit order matches the microcode decoder's {rst, nmi, irq} input group.
  typedef struct packed {
    logic rst;
    logic nmi;
    logic irq;
  } intr_t;

  localparam intr_t INTR_NONE  = '{rst: 1'b0, nmi: 1'b0, irq: 1'b0};
  localparam intr_t INTR_RESET = '{rst: 1'b1, nmi: 1'b0, irq: 1'b0};
  localparam intr_t INTR_NMI   = '{rst: 1'b0, nmi: 1'b1, irq: 1'b0};
  localparam intr_t INTR_IRQ   = '{rst: 1'b0, nmi: 1'b0, irq: 1'b1};

  localparam logic [7:0] BRK_OP = 8'h00;

endpackage

// File: rtl/k6502_seq_nmi_edge.sv
// NMI falling-edge detector and pending latch; runs every clock regardless of rdy.
module k6502_nmi_edge (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  input  logic take,
  output logic pend
);

  logic hist_q, hist_d;
  logic latch_q, latch_d;

  // A new edge wins over the clear strobe so an edge on the consuming fetch is kept.
  always_comb begin
    hist_d  = nmi_n;
    latch_d = (latch_q & ~take) | (hist_q & ~nmi_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= 1'b1;
      latch_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      latch_q <= latch_d;
    end
  end

  assign pend = latch_q;

endmodule

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: instruction register, one-hot cycle counter and
// the reset/NMI/IRQ sequence flags feeding the microcode decoder.
module k6502_seq #(
  parameter int unsigned CYC_W = k6502_defs::CYC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdy,
  input  logic [7:0]       di,
  input  logic             sync_next,
  input  logic             nmi_n,
  input  logic             irq_n,
  input  logic             i_flag,
  output logic [7:0]       ir,
  output logic [CYC_W-1:0] cycle,
  output logic             rst,
  output logic             nmi,
  output logic             irq,
  output logic             sync,
  output logic             seq_err
);

  import k6502_defs::*;

  logic [7:0]       ir_q, ir_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  intr_t            intr_q, intr_d;
  logic             err_q, err_d;
  logic             nmi_pend;
  logic             nmi_take;

  k6502_nmi_edge u_nmi_edge (
    .clk   (clk),
    .reset (reset),
    .nmi_n (nmi_n),
    .take  (nmi_take),
    .pend  (nmi_pend)
  );

  always_comb begin
    ir_d     = ir_q;
    cycle_d  = cycle_q;
    intr_d   = intr_q;
    err_d    = err_q;
    nmi_take = 1'b0;
    if (rdy) begin
      if (sync_next) begin
        cycle_d = '0;
        intr_d  = INTR_NONE;
      end else if (cycle_q == '0) begin
        cycle_d = CYC_W'(C_0);
        if (nmi_pend) begin
          ir_d     = BRK_OP;
          intr_d   = INTR_NMI;
          nmi_take = 1'b1;
        end else if (!irq_n && !i_flag) begin
          ir_d   = BRK_OP;
          intr_d = INTR_IRQ;
        end else begin
          ir_d = di;
        end
      end else if (cycle_q[CYC_W-1]) begin
        // Ran past the last cycle without SYNC-NEXT: force a fetch and flag it.
        cycle_d = '0;
        err_d   = 1'b1;
        intr_d  = INTR_NONE;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= BRK_OP;
      cycle_q <= CYC_W'(C_0);
      intr_q  <= INTR_RESET;
      err_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      cycle_q <= cycle_d;
      intr_q  <= intr_d;
      err_q   <= err_d;
    end
  end

  assign ir      = ir_q;
  assign cycle   = cycle_q;
  assign rst     = intr_q.rst;
  assign nmi     = intr_q.nmi;
  assign irq     = intr_q.irq;
  assign sync    = (cycle_q == '0);
  assign seq_err = err_q;

endmodule
